mlp_train_engine: RTL and testbench
===================================

// Module: mlp_train_engine
// PURPOSE
//   Parametrised two-layer perceptron with on-chip training of the output layer.
//   One time-multiplexed MAC runs the forward pass (hidden ReLU layer, then linear output).
//   In train mode it then applies an SGD update to the output weights.
//   Supersedes the fixed 2-neuron hidden/output/backprop cluster; sits under the top
//   between pin-level input capture and uo_out.
// PARAMETERS
//   N_IN      4   inputs per sample (unsigned, X_W bits each)
//   N_HID     2   hidden neurons
//   X_W       4   input width
//   W_W       8   weight width (signed two's complement)
//   H_W      10   hidden activation width (unsigned, post-ReLU)
//   Y_W      16   output / target / error width (signed)
//   LR_SHIFT  3   learning rate = 2^-LR_SHIFT (arithmetic right shift)
// PORTS
//   clk_i       in   1              clock, rising edge
//   rst_i       in   1              synchronous reset, active high
//   start_i     in   1              start a pass; sampled only in IDLE
//   train_i     in   1              1 = forward + update, 0 = forward only; sampled with start_i
//   x_i         in   N_IN*X_W       sample; x[k] = x_i[k*X_W +: X_W]
//   target_i    in   Y_W            signed target; sampled with start_i
//   wr_en_i     in   1              weight write strobe
//   wr_addr_i   in   8              0..N_HID*N_IN-1: hidden w[h][k] at h*N_IN+k; next N_HID: output v[j]
//   wr_data_i   in   W_W            weight value
//   busy_o      out  1              high in every state except IDLE
//   done_o      out  1              1-cycle pulse at pass end
//   y_o         out  Y_W            last output, held until next ERR state
//   err_o       out  Y_W            last target - y, saturated, held
//   zero_err_o  out  1              err_o == 0
// BEHAVIOUR
//   Reset:
//   - state=IDLE; busy_o, done_o, zero_err_o=0; y_o, err_o=0.
//   - All weights = 1; hidden regs = 0.
//   - Applies mid-pass too: the pass is abandoned with no partial weight update.
//   FSM: IDLE -> FWD_H -> FWD_O -> ERR -> [UPD if train] -> DONE -> IDLE.
//   - IDLE: start_i=1 latches x_i, target_i and train_i, then enters FWD_H.
//   - FWD_H: N_HID*N_IN cycles, one product x[k]*w[h][k] per cycle, k inner loop.
//     On the last k, h[h] = clamp(acc, 0, 2^H_W-1) (ReLU plus saturation); acc cleared.
//   - FWD_O: N_HID cycles, acc += h[j]*v[j] (signed).
//   - ERR: 1 cycle. y_o = sat_Y_W(acc); err_o = sat_Y_W(target - y_o).
//     zero_err_o is updated in the same cycle.
//   - UPD: N_HID cycles. v[j] = sat_W_W(v[j] + ((err*h[j]) >>> LR_SHIFT)).
//     The shift is arithmetic and floors toward -inf. Hidden weights are never trained.
//   - DONE: done_o=1 for exactly 1 cycle, then IDLE.
//   Latency: done_o is high in cycle L after the start edge.
//   - L = N_IN*N_HID + N_HID + 1 + (train ? N_HID : 0) + 1.
//   - Defaults: train L=14, infer L=12.
//   - Back-to-back: start_i may be asserted the cycle after done_o.
//   Arithmetic:
//   - Internal acc is wide enough to be overflow-free (>= X_W+W_W+clog2(N_IN)+1 bits for FWD_H;
//     H_W+W_W+clog2(N_HID)+1 for FWD_O).
//   - Saturation is applied only where stated.
//   Boundaries:
//   - start_i while busy_o is ignored.
//   - wr_en_i while busy_o is ignored. Out-of-range wr_addr_i is ignored.
//   - wr_en_i and start_i in the same IDLE cycle: the write commits and the pass uses the new value.
//   - Latched x/target/train are immune to input changes during a pass.
//   - err_o = 0 in train mode: UPD still runs and weights stay unchanged.
// TESTING
//   1 Reset, then read outputs -> all outputs 0; an inference pass with x={4,3,2,1} gives y_o=20.
//   2 Defaults, x={4,3,2,1}, target=24, train=1 -> y_o=20, err_o=4, v0=v1=6, done_o at cycle 14.
//     A following inference gives y_o=120.
//   3 Set w[0][*]=-5 via wr port, x={15,15,15,15}, infer -> h0 clamps to 0.
//     y_o=h1=60, done_o at cycle 12.
//   4 Set v0=127, err=+large (target=32767), train -> v0 saturates at 127.
//     With v0=-128 and negative err, v0 stays -128.
//   5 rst_i pulsed at cycle 10 of a train pass -> IDLE next cycle, all weights 1, no done_o.
//   6 start_i held high through a pass plus wr_en_i mid-pass -> exactly one pass per IDLE.
//     The mid-pass write is dropped; back-to-back start issues the next pass right after done_o.

Source files
------------

// File: rtl/mlp_train_engine.sv
// Two-layer perceptron (ReLU hidden layer, linear output) on a single shared MAC,
// with an optional SGD update of the output-layer weights after each forward pass.
module mlp_train_engine #(
  parameter int N_IN     = 4,
  parameter int N_HID    = 2,
  parameter int X_W      = 4,
  parameter int W_W      = 8,
  parameter int H_W      = 10,
  parameter int Y_W      = 16,
  parameter int LR_SHIFT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  train_i,
  input  logic [N_IN*X_W-1:0]   x_i,
  input  logic [Y_W-1:0]        target_i,
  input  logic                  wr_en_i,
  input  logic [7:0]            wr_addr_i,
  input  logic [W_W-1:0]        wr_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [Y_W-1:0]        y_o,
  output logic [Y_W-1:0]        err_o,
  output logic                  zero_err_o
);
  localparam int N_W   = N_HID * N_IN;
  localparam int ACC_H = X_W + W_W + $clog2(N_IN) + 1;
  localparam int ACC_O = H_W + W_W + $clog2(N_HID) + 1;
  localparam int ACC_U = Y_W + H_W + 2;
  localparam int ACC_A = (ACC_H > ACC_O) ? ACC_H : ACC_O;
  localparam int ACC_W = (ACC_A > ACC_U) ? ACC_A : ACC_U;
  localparam int K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int J_W   = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int I_W   = (N_W > 1) ? $clog2(N_W) : 1;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (Y_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2 ** (Y_W - 1)));
  localparam logic signed [ACC_W-1:0] W_MAX = ACC_W'((2 ** (W_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] W_MIN = ACC_W'(-(2 ** (W_W - 1)));
  localparam logic signed [ACC_W-1:0] H_MAX = ACC_W'((2 ** H_W) - 1);
  localparam logic signed [W_W-1:0]   W_ONE = W_W'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_FWD_H, ST_FWD_O, ST_ERR, ST_UPD, ST_DONE} state_t;

  state_t                  state_r, next_state_s;
  logic signed [W_W-1:0]   w_r [N_W];
  logic signed [W_W-1:0]   v_r [N_HID];
  logic [H_W-1:0]          h_r [N_HID];
  logic [X_W-1:0]          x_r [N_IN];
  logic signed [Y_W-1:0]   tgt_r;
  logic                    train_r;
  logic [K_W-1:0]          k_r;
  logic [J_W-1:0]          j_r;
  logic [I_W-1:0]          idx_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    busy_r, done_r, zero_err_r;
  logic signed [Y_W-1:0]   y_r, err_r;

  logic                    last_k_s, last_j_s;
  logic signed [ACC_W-1:0] mac_a_s, mac_b_s, prod_s, sum_s, diff_s, upd_s;
  logic signed [Y_W-1:0]   y_sat_s, err_sat_s;
  logic signed [W_W-1:0]   v_new_s;
  logic [H_W-1:0]          h_new_s;

  function automatic logic signed [Y_W-1:0] sat_y(input logic signed [ACC_W-1:0] a);
    if (a > Y_MAX)      return Y_W'(Y_MAX);
    else if (a < Y_MIN) return Y_W'(Y_MIN);
    else                return Y_W'(a);
  endfunction

  function automatic logic signed [W_W-1:0] sat_w(input logic signed [ACC_W-1:0] a);
    if (a > W_MAX)      return W_W'(W_MAX);
    else if (a < W_MIN) return W_W'(W_MIN);
    else                return W_W'(a);
  endfunction

  function automatic logic [H_W-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1])     return {H_W{1'b0}};
    else if (a > H_MAX) return {H_W{1'b1}};
    else                return H_W'(a);
  endfunction

  assign last_k_s = (k_r == K_W'(N_IN - 1));
  assign last_j_s = (j_r == J_W'(N_HID - 1));

  // Next-state selection for the pass sequencer
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_i) next_state_s = ST_FWD_H; else next_state_s = ST_IDLE;
      ST_FWD_H: if (last_k_s && last_j_s) next_state_s = ST_FWD_O; else next_state_s = ST_FWD_H;
      ST_FWD_O: if (last_j_s) next_state_s = ST_ERR; else next_state_s = ST_FWD_O;
      ST_ERR:   if (train_r) next_state_s = ST_UPD; else next_state_s = ST_DONE;
      ST_UPD:   if (last_j_s) next_state_s = ST_DONE; else next_state_s = ST_UPD;
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Shared MAC operand steering; UPD reuses the multiplier for err*h
  always_comb begin
    mac_a_s = {ACC_W{1'b0}};
    mac_b_s = {ACC_W{1'b0}};
    case (state_r)
      ST_FWD_H: begin
        mac_a_s = ACC_W'(signed'({1'b0, x_r[k_r]}));
        mac_b_s = ACC_W'(w_r[idx_r]);
      end
      ST_FWD_O: begin
        mac_a_s = ACC_W'(signed'({1'b0, h_r[j_r]}));
        mac_b_s = ACC_W'(v_r[j_r]);
      end
      ST_UPD: begin
        mac_a_s = ACC_W'(err_r);
        mac_b_s = ACC_W'(signed'({1'b0, h_r[j_r]}));
      end
      default: begin
        mac_a_s = {ACC_W{1'b0}};
        mac_b_s = {ACC_W{1'b0}};
      end
    endcase
    prod_s    = mac_a_s * mac_b_s;
    sum_s     = acc_r + prod_s;
    h_new_s   = relu_sat(sum_s);
    y_sat_s   = sat_y(acc_r);
    diff_s    = ACC_W'(tgt_r) - ACC_W'(y_sat_s);
    err_sat_s = sat_y(diff_s);
    upd_s     = (prod_s >>> LR_SHIFT) + ACC_W'(v_r[j_r]);
    v_new_s   = sat_w(upd_s);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Sample latch, loop counters, accumulator and hidden activations
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_IN; i++) x_r[i] <= {X_W{1'b0}};
      for (int i = 0; i < N_HID; i++) h_r[i] <= {H_W{1'b0}};
      tgt_r   <= {Y_W{1'b0}};
      train_r <= 1'b0;
      k_r     <= {K_W{1'b0}};
      j_r     <= {J_W{1'b0}};
      idx_r   <= {I_W{1'b0}};
      acc_r   <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            for (int i = 0; i < N_IN; i++) x_r[i] <= x_i[i*X_W +: X_W];
            tgt_r   <= target_i;
            train_r <= train_i;
          end
          k_r   <= {K_W{1'b0}};
          j_r   <= {J_W{1'b0}};
          idx_r <= {I_W{1'b0}};
          acc_r <= {ACC_W{1'b0}};
        end
        ST_FWD_H: begin
          idx_r <= idx_r + I_W'(1);
          if (last_k_s) begin
            h_r[j_r] <= h_new_s;
            acc_r    <= {ACC_W{1'b0}};
            k_r      <= {K_W{1'b0}};
            j_r      <= last_j_s ? {J_W{1'b0}} : j_r + J_W'(1);
          end else begin
            acc_r <= sum_s;
            k_r   <= k_r + K_W'(1);
          end
        end
        ST_FWD_O: begin
          acc_r <= sum_s;
          j_r   <= last_j_s ? {J_W{1'b0}} : j_r + J_W'(1);
        end
        ST_UPD:  j_r <= last_j_s ? {J_W{1'b0}} : j_r + J_W'(1);
        default: j_r <= j_r;
      endcase
    end
  end

  // Weight store: IDLE-only host writes, output-layer update during UPD
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_W; i++) w_r[i] <= W_ONE;
      for (int i = 0; i < N_HID; i++) v_r[i] <= W_ONE;
    end else if (state_r == ST_UPD) begin
      v_r[j_r] <= v_new_s;
    end else if (wr_en_i && (state_r == ST_IDLE)) begin
      if (wr_addr_i < 8'(N_W))
        w_r[wr_addr_i[I_W-1:0]] <= wr_data_i;
      else if (wr_addr_i < 8'(N_W + N_HID))
        v_r[J_W'(wr_addr_i - 8'(N_W))] <= wr_data_i;
    end
  end

  // Registered status and result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      y_r        <= {Y_W{1'b0}};
      err_r      <= {Y_W{1'b0}};
      zero_err_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != ST_IDLE);
      done_r <= (next_state_s == ST_DONE);
      if (state_r == ST_ERR) begin
        y_r        <= y_sat_s;
        err_r      <= err_sat_s;
        zero_err_r <= (err_sat_s == {Y_W{1'b0}});
      end
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign y_o        = y_r;
  assign err_o      = err_r;
  assign zero_err_o = zero_err_r;
endmodule

// File: tb/tb_mlp_train_engine.sv
// Self-checking bench for mlp_train_engine: hand-derived vector table, corner-case
// sequences, and randomized passes checked against an arithmetic reference model.
module tb_mlp_train_engine;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0, start_i = 1'b0, train_i = 1'b0, wr_en_i = 1'b0;
  logic [15:0] x_i = 16'h0, target_i = 16'h0;
  logic [7:0]  wr_addr_i = 8'h0, wr_data_i = 8'h0;
  logic        busy_o, done_o, zero_err_o;
  logic [15:0] y_o, err_o;

  int n_chk = 0, n_fail = 0;
  int mw[8];
  int mv[2];
  int exp_y, exp_e, last_lat;

  typedef struct {
    logic [15:0] x;
    int          t;
    bit          tr;
    int          y;
    int          e;
    int          z;
    int          lat;
  } vec_t;
  vec_t tbl[7];

  mlp_train_engine dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .train_i(train_i),
    .x_i(x_i), .target_i(target_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .busy_o(busy_o), .done_o(done_o), .y_o(y_o),
    .err_o(err_o), .zero_err_o(zero_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mw[i] = 1;
    for (int i = 0; i < 2; i++) mv[i] = 1;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a < 8) mw[a] = int'($signed(d));
    else if (a < 10) mv[a - 8] = int'($signed(d));
  endtask

  task automatic model_pass(input logic [15:0] x, input int t, input bit tr);
    int h[2];
    int acc, p, q;
    for (int j = 0; j < 2; j++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) acc += int'(x[k*4 +: 4]) * mw[j*4 + k];
      h[j] = clamp(acc, 0, 1023);
    end
    acc = h[0] * mv[0] + h[1] * mv[1];
    exp_y = clamp(acc, -32768, 32767);
    exp_e = clamp(t - exp_y, -32768, 32767);
    if (tr) begin
      for (int j = 0; j < 2; j++) begin
        p = exp_e * h[j];
        q = p / 8;
        if (p < 0 && (p % 8) != 0) q = q - 1;
        mv[j] = clamp(mv[j] + q, -128, 127);
      end
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; wr_en_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    @(posedge clk); #1;
    wr_en_i = 1'b0;
    model_write(a, d);
  endtask

  // Starts one pass from IDLE, scrambles the inputs mid-pass, checks against the model.
  task automatic run_pass(input logic [15:0] x, input int t, input bit tr,
                          input bit do_wr, input logic [7:0] wa, input logic [7:0] wd);
    int cyc;
    x_i = x; target_i = 16'(t); train_i = tr; start_i = 1'b1;
    if (do_wr) begin
      wr_en_i = 1'b1; wr_addr_i = wa; wr_data_i = wd;
      model_write(wa, wd);
    end
    model_pass(x, t, tr);
    @(posedge clk); #1;
    start_i = 1'b0; wr_en_i = 1'b0;
    x_i = 16'($urandom); target_i = 16'($urandom); train_i = 1'($urandom);
    chk("busy_in_pass", int'(busy_o), 1);
    cyc = 1;
    while (!done_o && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    last_lat = done_o ? cyc : -1;
    chk("latency", last_lat, 8 + 2 + 1 + (tr ? 2 : 0) + 1);
    chk("model_y", int'($signed(y_o)), exp_y);
    chk("model_err", int'($signed(err_o)), exp_e);
    chk("model_zero", int'(zero_err_o), int'(exp_e == 0));
    @(posedge clk); #1;
    chk("done_width", int'(done_o), 0);
    chk("idle_after_done", int'(busy_o), 0);
  endtask

  initial begin
    int ndone, first_done, second_done, idle_busy;

    tbl[0] = '{16'h1234, 0,      1'b0, 20,   -20,   0, 12};
    tbl[1] = '{16'h1234, 20,     1'b1, 20,   0,     1, 14};
    tbl[2] = '{16'h1234, 24,     1'b1, 20,   4,     0, 14};
    tbl[3] = '{16'h1234, 120,    1'b0, 120,  0,     1, 12};
    tbl[4] = '{16'hFFFF, 0,      1'b0, 720,  -720,  0, 12};
    tbl[5] = '{16'hFFFF, 32767,  1'b1, 720,  32047, 0, 14};
    tbl[6] = '{16'h1234, 0,      1'b0, 2540, -2540, 0, 12};

    do_reset();
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_zero", int'(zero_err_o), 0);
    chk("rst_y", int'(y_o), 0);
    chk("rst_err", int'(err_o), 0);

    for (int i = 0; i < 7; i++) begin
      run_pass(tbl[i].x, tbl[i].t, tbl[i].tr, 1'b0, 8'h0, 8'h0);
      chk("tbl_y", int'($signed(y_o)), tbl[i].y);
      chk("tbl_err", int'($signed(err_o)), tbl[i].e);
      chk("tbl_zero", int'(zero_err_o), tbl[i].z);
      chk("tbl_lat", last_lat, tbl[i].lat);
    end

    // Hidden neuron 0 driven negative: ReLU clamps it to 0
    do_reset();
    for (int k = 0; k < 4; k++) wr(8'(k), 8'hFB);
    run_pass(16'hFFFF, 0, 1'b0, 1'b0, 8'h0, 8'h0);
    chk("relu_y", int'($signed(y_o)), 60);
    chk("relu_lat", last_lat, 12);

    // Output weight saturation at both rails
    do_reset();
    wr(8'd8, 8'h7F);
    run_pass(16'h1234, 32767, 1'b1, 1'b0, 8'h0, 8'h0);
    chk("satp_y", int'($signed(y_o)), 1280);
    chk("satp_err", int'($signed(err_o)), 31487);
    run_pass(16'h1234, 0, 1'b0, 1'b0, 8'h0, 8'h0);
    chk("satp_after", int'($signed(y_o)), 2540);
    wr(8'd8, 8'h80);
    wr(8'd9, 8'h01);
    run_pass(16'h1234, -32768, 1'b1, 1'b0, 8'h0, 8'h0);
    chk("satn_y", int'($signed(y_o)), -1270);
    run_pass(16'h1234, 0, 1'b0, 1'b0, 8'h0, 8'h0);
    chk("satn_after", int'($signed(y_o)), -2560);

    // Write in the same IDLE cycle as start is used by that pass
    do_reset();
    run_pass(16'h1234, 0, 1'b0, 1'b1, 8'd8, 8'd5);
    chk("wr_with_start", int'($signed(y_o)), 60);

    // Reset in cycle 10 of a train pass abandons it
    do_reset();
    wr(8'd8, 8'd3);
    x_i = 16'h1234; target_i = 16'd24; train_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    ndone = 0;
    for (int c = 2; c <= 10; c++) begin
      if (done_o) ndone++;
      @(posedge clk); #1;
    end
    chk("mid_busy_c10", int'(busy_o), 1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_reset();
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_y", int'(y_o), 0);
    repeat (5) begin
      @(posedge clk); #1;
      if (done_o) ndone++;
    end
    chk("mid_rst_nodone", ndone, 0);
    run_pass(16'h1234, 0, 1'b0, 1'b0, 8'h0, 8'h0);
    chk("mid_rst_weights", int'($signed(y_o)), 20);

    // start held high: one pass per IDLE cycle, mid-pass write dropped
    do_reset();
    x_i = 16'h1234; target_i = 16'd0; train_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    ndone = 0; first_done = -1; second_done = -1; idle_busy = -1;
    for (int c = 1; c <= 25; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done_o) begin
        ndone++;
        if (first_done < 0) first_done = c; else second_done = c;
      end
      if (c == 5) begin wr_en_i = 1'b1; wr_addr_i = 8'd8; wr_data_i = 8'd50; end
      if (c == 6) wr_en_i = 1'b0;
      if (c == 13) idle_busy = int'(busy_o);
    end
    start_i = 1'b0;
    chk("b2b_ndone", ndone, 2);
    chk("b2b_first", first_done, 12);
    chk("b2b_second", second_done, 25);
    chk("b2b_idle", idle_busy, 0);
    chk("b2b_y", int'($signed(y_o)), 20);
    repeat (2) @(posedge clk);
    #1 chk("b2b_stop", int'(busy_o), 0);

    // Randomized passes against the reference model
    do_reset();
    for (int n = 0; n < 30; n++) begin
      for (int w = 0; w < int'($urandom_range(0, 3)); w++)
        wr(8'($urandom_range(0, 12)), 8'($urandom));
      run_pass(16'($urandom), int'($urandom_range(0, 65535)) - 32768, 1'($urandom),
               ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 12)), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
